// File: rtl/btn_pkg.sv
// Shared types and defaults for the pushbutton debouncer.
// Optional feature macro: BTN_DEBOUNCE_HOLD_REPEAT_EN (hold-to-repeat press pulses).
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 10000;
    localparam int unsigned REPEAT_DELAY_DEF    = 5000000;
    localparam int unsigned REPEAT_PERIOD_DEF   = 1000000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One pushbutton channel: 2-flop synchroniser, debounce FSM, saturating
// stability counter and registered level/press/release outputs.
// Optional feature macro: BTN_DEBOUNCE_HOLD_REPEAT_EN adds auto-repeat
// press pulses while the button stays accepted as pressed.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    db_state_t        r_state;
    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_level_nxt;
    logic             w_accept_press;
    logic             w_release_nxt;
    logic             w_press_nxt;

    // Two-flop synchroniser; the FSM only ever looks at r_sync2.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Next-state logic: a change is accepted only after the synchronised
    // input has held its new value for DEBOUNCE_CYCLES consecutive samples.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_accept_press = 1'b0;
        w_release_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt    = PRESSED;
                    w_accept_press = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!r_sync2) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = PRESSED;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = IDLE;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_level_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);
    end

`ifdef BTN_DEBOUNCE_HOLD_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = cnt_width(RPT_MAX);

    logic [RPT_W-1:0] r_rpt;
    logic [RPT_W-1:0] w_rpt_nxt;
    logic [RPT_W-1:0] w_rpt_limit;
    logic             r_rpt_first;
    logic             w_rpt_first_nxt;
    logic             w_rpt_hit;

    // Repeat counter: restarts only on a fresh acceptance, freezes outside
    // PRESSED, so a release bounce back into PRESSED keeps the cadence.
    always_comb begin
        w_rpt_nxt       = r_rpt;
        w_rpt_first_nxt = r_rpt_first;
        w_rpt_hit       = 1'b0;
        w_rpt_limit     = r_rpt_first ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
        if ((r_state == PRESS_WAIT) && (w_state_nxt == PRESSED)) begin
            w_rpt_nxt       = '0;
            w_rpt_first_nxt = 1'b0;
        end else if ((r_state == PRESSED) && r_sync2) begin
            if (r_rpt == w_rpt_limit) begin
                w_rpt_hit       = 1'b1;
                w_rpt_nxt       = '0;
                w_rpt_first_nxt = 1'b1;
            end else begin
                w_rpt_nxt = r_rpt + RPT_W'(1);
            end
        end
    end

    // Repeat counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rpt       <= '0;
            r_rpt_first <= 1'b0;
        end else begin
            r_rpt       <= w_rpt_nxt;
            r_rpt_first <= w_rpt_first_nxt;
        end
    end

    assign w_press_nxt = w_accept_press | w_rpt_hit;
`else
    logic w_unused_rpt;
    assign w_unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign w_press_nxt  = w_accept_press;
`endif

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/btn_debounce.sv
// Debouncer for NUM_BTN raw pushbuttons: one independent channel per bit,
// producing a clean level plus one-cycle press and release pulses.
// Optional feature macro: BTN_DEBOUNCE_HOLD_REPEAT_EN (auto-repeat on hold).
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_raw     (btn_raw[g]),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g]),
            .o_release (btn_release[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8. Edge k is the k-th rising edge after
// the stimulus starts; outputs are sampled 1 time unit after each edge.
module tb_btn_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    btn_debounce #(
        .NUM_BTN         (4),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] ep, input logic [3:0] er, input logic [3:0] el);
        chk({tag, " press"},   32'(btn_press),   32'(ep));
        chk({tag, " release"}, 32'(btn_release), 32'(er));
        chk({tag, " level"},   32'(btn_level),   32'(el));
    endtask

    // Drive raw for edge k, then check the outputs that edge produces.
    task automatic step(input string tag, input int k, input logic [3:0] raw,
                        input logic [3:0] ep, input logic [3:0] er, input logic [3:0] el);
        btn_raw = raw;
        @(posedge clk);
        #1;
        chk_outs($sformatf("%s k=%0d", tag, k), ep, er, el);
    endtask

    task automatic do_reset();
        btn_raw = 4'b0000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_outs("reset", 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = 4'b0000;

        // Clean press on bit 0: pulse after edge 6, level held afterwards.
        do_reset();
        for (int k = 0; k < 10; k++)
            step("clean", k, 4'b0001, (k == 6) ? 4'b0001 : 4'b0000, 4'b0000,
                 (k >= 6) ? 4'b0001 : 4'b0000);

        // Bounce on bit 1: 1,0,1,0 then stable 1 from edge 4 -> press after edge 10.
        do_reset();
        for (int k = 0; k < 14; k++)
            step("bounce", k, (k < 4 && (k % 2) == 1) ? 4'b0000 : 4'b0010,
                 (k == 10) ? 4'b0010 : 4'b0000, 4'b0000,
                 (k >= 10) ? 4'b0010 : 4'b0000);

        // Release on bit 2: high for edges 0..19, low at 20, glitch high at 21..22,
        // low from 23 -> release after edge 29.
        do_reset();
        for (int k = 0; k < 35; k++)
            step("release", k, (k < 20 || k == 21 || k == 22) ? 4'b0100 : 4'b0000,
                 (k == 6) ? 4'b0100 : 4'b0000,
                 (k == 29) ? 4'b0100 : 4'b0000,
                 (k >= 6 && k < 29) ? 4'b0100 : 4'b0000);

        // All four buttons in the same cycle.
        do_reset();
        for (int k = 0; k < 9; k++)
            step("simul", k, 4'b1111, (k == 6) ? 4'b1111 : 4'b0000, 4'b0000,
                 (k >= 6) ? 4'b1111 : 4'b0000);

        // Reset while PRESSED clears the level immediately.
        for (int k = 9; k < 11; k++)
            step("simul", k, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        #2;
        rst = 1'b1;
        #1;
        chk_outs("rst async pressed", 4'b0000, 4'b0000, 4'b0000);
        @(posedge clk);
        #1;
        chk_outs("rst held pressed", 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;

        // Held through deassertion: debounced from IDLE, press after edge 6.
        // Then reset again during PRESS_WAIT (edges 0..3) and repeat.
        btn_raw = 4'b0001;
        for (int k = 0; k < 4; k++)
            step("rst pw pre", k, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        #2;
        rst = 1'b1;
        #1;
        chk_outs("rst async pw", 4'b0000, 4'b0000, 4'b0000);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_outs("rst held pw", 4'b0000, 4'b0000, 4'b0000);
        end
        rst = 1'b0;
        for (int k = 0; k < 9; k++)
            step("rst pw post", k, 4'b0001, (k == 6) ? 4'b0001 : 4'b0000, 4'b0000,
                 (k >= 6) ? 4'b0001 : 4'b0000);

        // Long hold on bit 3: auto-repeat at +20, +28, ... when enabled.
        do_reset();
        for (int k = 0; k < 66; k++) begin
            logic rep;
`ifdef BTN_DEBOUNCE_HOLD_REPEAT_EN
            rep = (k >= 26) && (((k - 26) % 8) == 0);
`else
            rep = 1'b0;
`endif
            step("hold", k, 4'b1000, (k == 6 || rep) ? 4'b1000 : 4'b0000, 4'b0000,
                 (k >= 6) ? 4'b1000 : 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
